// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding, default bus widths and the width of the read-wait counter.
package memory_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF   = 10;
    localparam int DATA_WIDTH_DEF   = 16;
    localparam int WAIT_COUNT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

endpackage

// File: rtl/memory_arbiter_rr_select.sv
// rr_select_2: combinational two-way round-robin pick.
//   req_0, req_1  : request lines
//   last_grant    : index granted most recently
//   grant_valid   : at least one request present
//   grant_index   : winning requester
module rr_select_2 (
    input  logic req_0,
    input  logic req_1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_index
);

    always_comb begin
        grant_valid = req_0 | req_1;
        // On a tie the requester that did not win last time goes first.
        grant_index = (req_0 & req_1) ? ~last_grant : req_1;
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port synchronous-read memory between
// two req/ack requesters. One access per grant, all outputs registered.
//   clock, reset_n                      : clock, async active-low reset
//   req_x/write_x/address_x/data_x      : requester x command (x = 0, 1)
//   ack_x                               : one-cycle completion pulse
//   read_data                           : data of the last completed read
//   busy                                : FSM not in IDLE
//   mem_enable/mem_write/mem_address/
//   mem_data_in/mem_data_out            : memory port
//
// state   | meaning
// IDLE    | sample requests, grant and latch command
// ACCESS  | memory enabled for exactly one cycle
// WAIT    | read in flight, counting down READ_LATENCY
// RESPOND | ack to winner, record last grant
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_0,
    input  logic                  write_0,
    input  logic [ADDR_WIDTH-1:0] address_0,
    input  logic [DATA_WIDTH-1:0] data_0,
    output logic                  ack_0,
    input  logic                  req_1,
    input  logic                  write_1,
    input  logic [ADDR_WIDTH-1:0] address_1,
    input  logic [DATA_WIDTH-1:0] data_1,
    output logic                  ack_1,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  busy,
    output logic                  mem_enable,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    state_t                      state_q, state_d;
    logic                        winner_q, winner_d;
    logic                        cmd_write_q, cmd_write_d;
    logic                        last_grant_q, last_grant_d;
    logic [WAIT_COUNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                        ack_0_q, ack_0_d;
    logic                        ack_1_q, ack_1_d;
    logic [DATA_WIDTH-1:0]       read_data_q, read_data_d;
    logic                        busy_q, busy_d;
    logic                        mem_enable_q, mem_enable_d;
    logic                        mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]       mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]       mem_data_in_q, mem_data_in_d;

    logic grant_valid;
    logic grant_index;

    rr_select_2 u_rr_select (
        .req_0       (req_0),
        .req_1       (req_1),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    // mem_address/mem_data_in double as the command address/data registers:
    // they are loaded on the grant edge and held until the next grant.
    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        cmd_write_d   = cmd_write_q;
        last_grant_d  = last_grant_q;
        wait_cnt_d    = wait_cnt_q;
        read_data_d   = read_data_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        ack_0_d       = 1'b0;
        ack_1_d       = 1'b0;
        mem_enable_d  = 1'b0;
        mem_write_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    winner_d      = grant_index;
                    cmd_write_d   = grant_index ? write_1 : write_0;
                    mem_address_d = grant_index ? address_1 : address_0;
                    mem_data_in_d = grant_index ? data_1 : data_0;
                    // Outputs are registered, so the enable for ACCESS is set here.
                    mem_enable_d  = 1'b1;
                    mem_write_d   = grant_index ? write_1 : write_0;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                if (cmd_write_q) begin
                    ack_0_d = ~winner_q;
                    ack_1_d = winner_q;
                    state_d = RESPOND;
                end else begin
                    wait_cnt_d = WAIT_COUNT_WIDTH'(READ_LATENCY);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_COUNT_WIDTH'(1)) begin
                    read_data_d = mem_data_out;
                    ack_0_d     = ~winner_q;
                    ack_1_d     = winner_q;
                    state_d     = RESPOND;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_COUNT_WIDTH'(1);
                end
            end
            RESPOND: begin
                last_grant_d = winner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            winner_q      <= 1'b0;
            cmd_write_q   <= 1'b0;
            last_grant_q  <= 1'b1;
            wait_cnt_q    <= '0;
            ack_0_q       <= 1'b0;
            ack_1_q       <= 1'b0;
            read_data_q   <= '0;
            busy_q        <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            cmd_write_q   <= cmd_write_d;
            last_grant_q  <= last_grant_d;
            wait_cnt_q    <= wait_cnt_d;
            ack_0_q       <= ack_0_d;
            ack_1_q       <= ack_1_d;
            read_data_q   <= read_data_d;
            busy_q        <= busy_d;
            mem_enable_q  <= mem_enable_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign ack_0       = ack_0_q;
    assign ack_1       = ack_1_q;
    assign read_data   = read_data_q;
    assign busy        = busy_q;
    assign mem_enable  = mem_enable_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    typedef struct {
        int          who;
        int          cyc;
        bit          chk;
        logic [15:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT with READ_LATENCY = 1 ----------------
    logic        r0 = 0, w0 = 0, r1 = 0, w1 = 0;
    logic [9:0]  a0 = 0, a1 = 0;
    logic [15:0] d0 = 0, d1 = 0;
    logic        ack_0, ack_1, busy, mem_enable, mem_write;
    logic [15:0] read_data, mem_data_in, mem_data_out;
    logic [9:0]  mem_address;

    memory_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .READ_LATENCY(1)) dut (
        .clock(clk), .reset_n(reset_n),
        .req_0(r0), .write_0(w0), .address_0(a0), .data_0(d0), .ack_0(ack_0),
        .req_1(r1), .write_1(w1), .address_1(a1), .data_1(d1), .ack_1(ack_1),
        .read_data(read_data), .busy(busy),
        .mem_enable(mem_enable), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_enable && mem_write) mem[mem_address] <= mem_data_in;
        mem_data_out <= (mem_enable && !mem_write) ? mem[mem_address] : 16'hDEAD;
    end

    // ---------------- DUT with READ_LATENCY = 3 ----------------
    logic        s0 = 0, x0 = 0, s1 = 0, x1 = 0;
    logic [9:0]  b0 = 0, b1 = 0;
    logic [15:0] e0 = 0, e1 = 0;
    logic        ack3_0, ack3_1, busy3, en3, we3;
    logic [15:0] rd3, din3, dout3;
    logic [9:0]  addr3;

    memory_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .READ_LATENCY(3)) dut3 (
        .clock(clk), .reset_n(reset_n),
        .req_0(s0), .write_0(x0), .address_0(b0), .data_0(e0), .ack_0(ack3_0),
        .req_1(s1), .write_1(x1), .address_1(b1), .data_1(e1), .ack_1(ack3_1),
        .read_data(rd3), .busy(busy3),
        .mem_enable(en3), .mem_write(we3),
        .mem_address(addr3), .mem_data_in(din3),
        .mem_data_out(dout3)
    );

    logic [15:0] mem3 [0:1023];
    logic [15:0] pipe3 [3];
    always @(posedge clk) begin
        if (en3 && we3) mem3[addr3] <= din3;
        pipe3[0] <= (en3 && !we3) ? mem3[addr3] : 16'hDEAD;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign dout3 = pipe3[2];

    // ---------------- scoreboard ----------------
    exp_t        q0[$];
    exp_t        q3[$];
    logic [25:0] qwr[$];
    bit          prev_en = 0, prev_en3 = 0;
    int          en3_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (ack_0 || ack_1) begin
                check("ack_exclusive", 32'(ack_0 & ack_1), 32'd0);
                if (q0.size() == 0) begin
                    check("unexpected_ack", 32'(ack_1), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("ack_who", 32'(ack_1), 32'(e.who));
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.chk) check("read_data", 32'(read_data), 32'(e.rd));
                end
            end
            if (mem_enable) begin
                check("enable_single", 32'(prev_en), 32'd0);
                if (mem_write) begin
                    if (qwr.size() == 0) check("unexpected_write", 32'({mem_address, mem_data_in}), 32'hFFFF_FFFF);
                    else check("write_cmd", 32'({mem_address, mem_data_in}), 32'(qwr.pop_front()));
                end
            end
            if (ack3_0 || ack3_1) begin
                if (q3.size() == 0) begin
                    check("unexpected_ack3", 32'(ack3_1), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q3.pop_front();
                    check("ack3_who", 32'(ack3_1), 32'(e.who));
                    check("ack3_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.chk) check("read_data3", 32'(rd3), 32'(e.rd));
                end
            end
            if (en3) begin
                check("enable3_single", 32'(prev_en3), 32'd0);
                en3_pulses++;
            end
        end
        prev_en  = mem_enable;
        prev_en3 = en3;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int d, input int who, input logic rq, input logic wr,
                           input logic [9:0] a, input logic [15:0] dat);
        if (d == 0 && who == 0) begin r0 = rq; w0 = wr; a0 = a; d0 = dat; end
        if (d == 0 && who == 1) begin r1 = rq; w1 = wr; a1 = a; d1 = dat; end
        if (d == 1 && who == 0) begin s0 = rq; x0 = wr; b0 = a; e0 = dat; end
        if (d == 1 && who == 1) begin s1 = rq; x1 = wr; b1 = a; e1 = dat; end
    endtask

    function automatic logic ack_of(input int d, input int who);
        if (d == 0) return (who == 0) ? ack_0 : ack_1;
        return (who == 0) ? ack3_0 : ack3_1;
    endfunction

    // Called at posedge+1 with the DUT idle; the request is sampled this cycle.
    task automatic access(input int d, input int who, input logic wr, input logic [9:0] a,
                          input logic [15:0] dat, input logic [15:0] rd_exp, input bit early_drop);
        exp_t e;
        bit   got;
        int   lat;
        lat   = (d == 0) ? 1 : 3;
        e.who = who;
        e.cyc = cyc + (wr ? 2 : 2 + lat);
        e.chk = !wr;
        e.rd  = rd_exp;
        if (d == 0) q0.push_back(e); else q3.push_back(e);
        if (d == 0 && wr) qwr.push_back({a, dat});
        set_req(d, who, 1'b1, wr, a, dat);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (early_drop && i == 0) set_req(d, who, 1'b0, wr, a, dat);
            if (ack_of(d, who)) begin got = 1; break; end
        end
        set_req(d, who, 1'b0, wr, a, dat);
        check("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int nacks;
        int n;
        exp_t e;

        #12;
        check("reset_outputs", 32'({ack_0, ack_1, busy, mem_enable, mem_write, mem_address, mem_data_in} | 32'(read_data)), 32'd0);
        check("reset_outputs3", 32'({ack3_0, ack3_1, busy3, en3, we3, addr3, din3} | 32'(rd3)), 32'd0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", 32'(busy), 32'd0);

        // Single write from requester 0.
        access(0, 0, 1'b1, 10'h055, 16'hBEEF, 16'h0, 0);
        idle_cycles(2);
        // Single read from requester 1.
        access(0, 1, 1'b0, 10'h055, 16'h0, 16'hBEEF, 0);
        idle_cycles(2);

        // Contention: both writing continuously, last grant was 1 so 0 leads.
        n = cyc;
        for (int k = 0; k < 4; k++) begin
            e.who = k % 2;
            e.cyc = n + 2 + 3 * k;
            e.chk = 0;
            e.rd  = 0;
            q0.push_back(e);
            qwr.push_back((k % 2 == 0) ? {10'h100, 16'h1111} : {10'h200, 16'h2222});
        end
        set_req(0, 0, 1'b1, 1'b1, 10'h100, 16'h1111);
        set_req(0, 1, 1'b1, 1'b1, 10'h200, 16'h2222);
        nacks = 0;
        for (int i = 0; i < 40 && nacks < 4; i++) begin
            @(posedge clk); #1;
            if (ack_0 || ack_1) nacks++;
        end
        set_req(0, 0, 1'b0, 1'b1, 10'h100, 16'h1111);
        set_req(0, 1, 1'b0, 1'b1, 10'h200, 16'h2222);
        check("contention_acks", 32'(nacks), 32'd4);
        idle_cycles(2);
        check("mem_100", 32'(mem[10'h100]), 32'h1111);
        check("mem_200", 32'(mem[10'h200]), 32'h2222);

        // Requester 0 drops req while its read is in ACCESS.
        access(0, 0, 1'b0, 10'h100, 16'h0, 16'h1111, 1);
        idle_cycles(6);
        check("drop_no_retry", 32'(busy), 32'd0);

        // Reset in the middle of a read.
        set_req(0, 1, 1'b1, 1'b0, 10'h200, 16'h0);
        idle_cycles(2);
        check("in_wait_busy", 32'({busy, mem_enable}), 32'b10);
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({ack_0, ack_1, busy, mem_enable, mem_write, mem_address, mem_data_in} | 32'(read_data)), 32'd0);
        set_req(0, 1, 1'b0, 1'b0, 10'h200, 16'h0);
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        idle_cycles(4);
        check("no_ack_after_reset", 32'(busy), 32'd0);
        // Tie after reset: requester 0 must win.
        set_req(0, 1, 1'b1, 1'b0, 10'h055, 16'h0);
        access(0, 0, 1'b0, 10'h055, 16'h0, 16'hBEEF, 0);
        set_req(0, 1, 1'b0, 1'b0, 10'h055, 16'h0);
        idle_cycles(3);

        // READ_LATENCY = 3 instance.
        en3_pulses = 0;
        access(1, 0, 1'b1, 10'h1A3, 16'hC0DE, 16'h0, 0);
        idle_cycles(2);
        access(1, 1, 1'b0, 10'h1A3, 16'h0, 16'hC0DE, 0);
        idle_cycles(3);
        check("mem3_1a3", 32'(mem3[10'h1A3]), 32'hC0DE);
        check("enable3_pulses", 32'(en3_pulses), 32'd2);

        idle_cycles(3);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q3_drained", 32'(q3.size()), 32'd0);
        check("qwr_drained", 32'(qwr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
